// File: rtl/patrol_movecollision.sv
// patrol_movecollision: fixed-point 2-D patrol mover for hazards and platforms.
// Position steps once per enabled frame inside a per-axis window, with bounce,
// wrap or dwell-then-bounce end behaviour and a reverse request from collision logic.
module patrol_movecollision #(
    parameter int unsigned CoordW      = 11,
    parameter int unsigned FpShift     = 6,
    parameter int          InitialX    = 192,
    parameter int          InitialY    = 64,
    parameter int          MinX        = 192,
    parameter int          MaxX        = 383,
    parameter int          MinY        = 64,
    parameter int          MaxY        = 64,
    parameter int          SpeedX      = 20,
    parameter int          SpeedY      = 0,
    parameter int unsigned Mode        = 0,   // 0 bounce, 1 wrap, 2 dwell
    parameter int unsigned DwellFrames = 30
) (
    input  logic              clk_i,
    input  logic              reset_n_i,      // active-high despite the legacy name
    input  logic              start_of_frame_i,
    input  logic              enable_i,
    input  logic              hit_i,
    output logic [CoordW-1:0] top_left_x_o,
    output logic [CoordW-1:0] top_left_y_o,
    output logic [CoordW-1:0] speed_x_o,
    output logic [CoordW-1:0] speed_y_o,
    output logic              moving_o,
    output logic              edge_pulse_o
);

    localparam int          FpMul     = 1 << FpShift;
    localparam int          MinXFp    = MinX * FpMul;
    localparam int          MaxXFp    = MaxX * FpMul;
    localparam int          MinYFp    = MinY * FpMul;
    localparam int          MaxYFp    = MaxY * FpMul;
    localparam int          InitXFp   = InitialX * FpMul;
    localparam int          InitYFp   = InitialY * FpMul;
    localparam bit          WrapMode  = (Mode == 1);
    localparam bit          DwellMode = (Mode == 2);
    // A degenerate window or zero speed pins the axis in place.
    localparam bit          PinX      = (MinX == MaxX) || (SpeedX == 0);
    localparam bit          PinY      = (MinY == MaxY) || (SpeedY == 0);
    localparam int unsigned CntW      = $clog2(DwellFrames + 1);

    typedef enum logic [0:0] {StMove, StDwell} state_e;

    typedef struct packed {
        logic [31:0] pos;
        logic [31:0] vel;
        logic        hit_edge;
    } step_t;

    state_e             state_q, state_d;
    logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [31:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               hit_pend_q, hit_pend_d;
    logic               edge_q, edge_d;

    logic               update;
    logic               flip;
    logic               dwell_trig;
    step_t              step_x, step_y;
    logic signed [31:0] pix_x, pix_y;

    // One frame step of a single axis; the clamped velocity always points back inside.
    function automatic step_t axis_step(
        input logic signed [31:0] pos,
        input logic signed [31:0] vel,
        input logic               flp,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi,
        input logic               wrap,
        input logic               pinned
    );
        logic signed [31:0] v;
        logic signed [31:0] mag;
        logic signed [31:0] nxt;
        step_t              r;
        v          = flp ? -vel : vel;
        mag        = (v < 0) ? -v : v;
        nxt        = pos + v;
        r.pos      = nxt;
        r.vel      = v;
        r.hit_edge = 1'b0;
        if (pinned) begin
            r.pos = pos;
            r.vel = '0;
        end else if (wrap) begin
            if (nxt > hi) begin
                r.pos      = lo + (nxt - hi - 32'sd1);
                r.hit_edge = 1'b1;
            end else if (nxt < lo) begin
                r.pos      = hi - (lo - nxt - 32'sd1);
                r.hit_edge = 1'b1;
            end
        end else begin
            if (nxt >= hi) begin
                r.pos      = hi;
                r.vel      = -mag;
                r.hit_edge = 1'b1;
            end else if (nxt <= lo) begin
                r.pos      = lo;
                r.vel      = mag;
                r.hit_edge = 1'b1;
            end
        end
        return r;
    endfunction

    assign update = start_of_frame_i & enable_i;
    // A hit arriving with the frame strobe applies to that same update.
    assign flip   = hit_pend_q | hit_i;

    // Candidate per-axis results for this frame and whether X starts a dwell.
    always_comb begin
        step_x     = axis_step(pos_x_q, vel_x_q, flip, MinXFp, MaxXFp, WrapMode, PinX);
        step_y     = axis_step(pos_y_q, vel_y_q, flip, MinYFp, MaxYFp, WrapMode, PinY);
        dwell_trig = DwellMode & step_x.hit_edge;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            state_q <= StMove;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: dwell entered from an X edge, left when the count runs out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMove:  if (update && dwell_trig) state_d = StDwell;
            StDwell: if (update && (cnt_q <= CntW'(1))) state_d = StMove;
            default: state_d = StMove;
        endcase
    end

    // FSM outputs.
    always_comb begin
        moving_o = (state_q == StMove) & enable_i;
    end

    // Datapath next state: motion in MOVE, countdown in DWELL, hold otherwise.
    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        cnt_d      = cnt_q;
        hit_pend_d = hit_pend_q;
        edge_d     = 1'b0;
        unique case (state_q)
            StMove: begin
                if (update) begin
                    pos_x_d    = step_x.pos;
                    vel_x_d    = step_x.vel;
                    pos_y_d    = step_y.pos;
                    vel_y_d    = step_y.vel;
                    edge_d     = step_x.hit_edge | step_y.hit_edge;
                    hit_pend_d = 1'b0;
                    if (dwell_trig) cnt_d = CntW'(DwellFrames);
                end else if (hit_i) begin
                    hit_pend_d = 1'b1;
                end
            end
            StDwell: begin
                hit_pend_d = 1'b0;
                if (update) cnt_d = cnt_q - CntW'(1);
            end
            default: hit_pend_d = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge reset_n_i) begin
        if (reset_n_i) begin
            pos_x_q    <= InitXFp;
            pos_y_q    <= InitYFp;
            vel_x_q    <= SpeedX;
            vel_y_q    <= SpeedY;
            cnt_q      <= '0;
            hit_pend_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            cnt_q      <= cnt_d;
            hit_pend_q <= hit_pend_d;
            edge_q     <= edge_d;
        end
    end

    // Arithmetic shift so negative positions floor.
    assign pix_x        = pos_x_q >>> FpShift;
    assign pix_y        = pos_y_q >>> FpShift;
    assign top_left_x_o = pix_x[CoordW-1:0];
    assign top_left_y_o = pix_y[CoordW-1:0];
    assign speed_x_o    = vel_x_q[CoordW-1:0];
    assign speed_y_o    = vel_y_q[CoordW-1:0];
    assign edge_pulse_o = edge_q;

    logic unused_bits;
    assign unused_bits = ^{pix_x[31:CoordW], pix_y[31:CoordW],
                           vel_x_q[31:CoordW], vel_y_q[31:CoordW]};

endmodule

// File: tb/tb_patrol_movecollision.sv
// Bench for patrol_movecollision: three instances (bounce, wrap, dwell) share one
// randomized stimulus stream; a window-rule model feeds a scoreboard queue.
module tb_patrol_movecollision;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sof, en, hit;
    logic [10:0] tlx[3], tly[3], spx[3], spy[3];
    logic        mov[3], edg[3];

    patrol_movecollision #(.Mode(0)) u_bounce (
        .clk_i(clk), .reset_n_i(rst), .start_of_frame_i(sof), .enable_i(en), .hit_i(hit),
        .top_left_x_o(tlx[0]), .top_left_y_o(tly[0]), .speed_x_o(spx[0]),
        .speed_y_o(spy[0]), .moving_o(mov[0]), .edge_pulse_o(edg[0])
    );

    patrol_movecollision #(.Mode(1), .MaxY(80), .SpeedY(37)) u_wrap (
        .clk_i(clk), .reset_n_i(rst), .start_of_frame_i(sof), .enable_i(en), .hit_i(hit),
        .top_left_x_o(tlx[1]), .top_left_y_o(tly[1]), .speed_x_o(spx[1]),
        .speed_y_o(spy[1]), .moving_o(mov[1]), .edge_pulse_o(edg[1])
    );

    patrol_movecollision #(.Mode(2), .MaxY(90), .SpeedY(50)) u_dwell (
        .clk_i(clk), .reset_n_i(rst), .start_of_frame_i(sof), .enable_i(en), .hit_i(hit),
        .top_left_x_o(tlx[2]), .top_left_y_o(tly[2]), .speed_x_o(spx[2]),
        .speed_y_o(spy[2]), .moving_o(mov[2]), .edge_pulse_o(edg[2])
    );

    typedef struct {
        int due;
        int inst;
        int x;
        int y;
        int sx;
        int sy;
        bit ed;
        bit mv;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Model: per instance, per axis (0 = X, 1 = Y), fixed point with 64 units per pixel.
    int   lo_px[3][2], hi_px[3][2], spd[3][2], init_px[3][2], mode_of[3];
    int   m_pos[3][2], m_vel[3][2], m_cnt[3];
    bit   m_dwell[3], m_pend[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int sx11(input logic [10:0] v);
        return int'($signed(v));
    endfunction

    task automatic push_all();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.due  = cyc + 1;
            e.inst = i;
            e.x    = m_pos[i][0] >>> 6;
            e.y    = m_pos[i][1] >>> 6;
            e.sx   = m_vel[i][0];
            e.sy   = m_vel[i][1];
            e.ed   = 1'b0;
            e.mv   = !m_dwell[i];
            q.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 2; a++) begin
                m_pos[i][a] = init_px[i][a] * 64;
                m_vel[i][a] = spd[i][a];
            end
            m_cnt[i]   = 0;
            m_dwell[i] = 1'b0;
            m_pend[i]  = 1'b0;
        end
    endtask

    // Window rule for one axis; the speed magnitude never changes, only its sign.
    task automatic axis(input int i, input int a, input bit flp, output bit ed);
        int lo, hi, v, n;
        ed = 1'b0;
        lo = lo_px[i][a] * 64;
        hi = hi_px[i][a] * 64;
        if (lo == hi || spd[i][a] == 0) begin
            m_vel[i][a] = 0;
            return;
        end
        v = flp ? -m_vel[i][a] : m_vel[i][a];
        n = m_pos[i][a] + v;
        if (mode_of[i] == 1) begin
            if (n > hi) begin
                n  = lo + (n - hi - 1);
                ed = 1'b1;
            end else if (n < lo) begin
                n  = hi - (lo - n - 1);
                ed = 1'b1;
            end
            m_pos[i][a] = n;
            m_vel[i][a] = v;
        end else begin
            if (n >= hi) begin
                m_pos[i][a] = hi;
                m_vel[i][a] = -spd[i][a];
                ed          = 1'b1;
            end else if (n <= lo) begin
                m_pos[i][a] = lo;
                m_vel[i][a] = spd[i][a];
                ed          = 1'b1;
            end else begin
                m_pos[i][a] = n;
                m_vel[i][a] = v;
            end
        end
    endtask

    task automatic model_step(input bit s, input bit e, input bit h);
        bit upd;
        upd = s && e;
        for (int i = 0; i < 3; i++) begin
            bit ex, ey, any;
            any = 1'b0;
            if (!m_dwell[i]) begin
                if (upd) begin
                    axis(i, 0, m_pend[i] | h, ex);
                    axis(i, 1, m_pend[i] | h, ey);
                    any       = ex | ey;
                    m_pend[i] = 1'b0;
                    if (mode_of[i] == 2 && ex) begin
                        m_dwell[i] = 1'b1;
                        m_cnt[i]   = 30;
                    end
                end else if (h) begin
                    m_pend[i] = 1'b1;
                end
            end else begin
                m_pend[i] = 1'b0;
                if (upd) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) m_dwell[i] = 1'b0;
                end
            end
            if (upd) begin
                exp_t ent;
                ent.due  = cyc + 1;
                ent.inst = i;
                ent.x    = m_pos[i][0] >>> 6;
                ent.y    = m_pos[i][1] >>> 6;
                ent.sx   = m_vel[i][0];
                ent.sy   = m_vel[i][1];
                ent.ed   = any;
                ent.mv   = !m_dwell[i];
                q.push_back(ent);
            end
        end
    endtask

    // Inputs change just after the falling edge, right after the monitor has sampled.
    task automatic slot(input bit s, input bit e, input bit h);
        @(negedge clk);
        #1;
        rst = 1'b0;
        sof = s;
        en  = e;
        hit = h;
        model_step(s, e, h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        sof = 1'b0;
        en  = 1'b0;
        hit = 1'b0;
        model_reset();
        push_all();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare every due scoreboard entry; otherwise edge pulses must be idle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due <= cyc) begin
                while (q.size() > 0 && q[0].due <= cyc) begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("top_left_x[%0d]", e.inst), sx11(tlx[e.inst]), e.x);
                    chk($sformatf("top_left_y[%0d]", e.inst), sx11(tly[e.inst]), e.y);
                    chk($sformatf("speed_x[%0d]", e.inst), sx11(spx[e.inst]), e.sx);
                    chk($sformatf("speed_y[%0d]", e.inst), sx11(spy[e.inst]), e.sy);
                    chk($sformatf("edge_pulse[%0d]", e.inst), int'(edg[e.inst]), int'(e.ed));
                    chk($sformatf("moving[%0d]", e.inst), int'(mov[e.inst]),
                        int'(e.mv && en));
                end
            end else begin
                for (int i = 0; i < 3; i++) chk($sformatf("edge_idle[%0d]", i), int'(edg[i]), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        rst = 1'b1;
        sof = 1'b0;
        en  = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode_of[i]    = i;
            lo_px[i][0]   = 192;
            hi_px[i][0]   = 383;
            spd[i][0]     = 20;
            init_px[i][0] = 192;
            lo_px[i][1]   = 64;
            init_px[i][1] = 64;
        end
        hi_px[0][1] = 64; spd[0][1] = 0;
        hi_px[1][1] = 80; spd[1][1] = 37;
        hi_px[2][1] = 90; spd[2][1] = 50;

        do_reset();

        // Clean run, one frame every other cycle: reaches X edges on all three instances.
        for (int k = 0; k < 1400; k++) slot(k[0], 1'b1, 1'b0);

        // Random frames, enable drops and reverse requests.
        for (int k = 0; k < 3000; k++) begin
            slot($urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) == 0);
        end

        // Directed: drive the dwell instance into its dwell.
        do_reset();
        guard = 0;
        while (!m_dwell[2] && guard < 2000) begin
            slot(1'b1, 1'b1, 1'b0);
            guard++;
        end
        chk("dwell_reached", int'(m_dwell[2]), 1);

        // Hits during dwell, then frozen frames with enable low.
        slot(1'b1, 1'b1, 1'b1);
        slot(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            slot(1'b1, 1'b0, 1'b0);
            slot(1'b0, 1'b0, 1'b1);
        end
        guard = 0;
        while (m_dwell[2] && guard < 100) begin
            slot(1'b1, 1'b1, 1'b0);
            guard++;
        end
        chk("dwell_left", int'(m_dwell[2]), 0);
        for (int k = 0; k < 3; k++) slot(1'b1, 1'b1, 1'b0);

        // Pending hit, then a hit coinciding with the frame strobe.
        slot(1'b0, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b0);
        slot(1'b1, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b0);

        // Reset in the middle of motion, then resume.
        do_reset();
        for (int k = 0; k < 6; k++) slot(1'b1, 1'b1, 1'b0);
        slot(1'b0, 1'b0, 1'b0);
        slot(1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
